// File: rtl/aria_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aria_pkg                                                             |
// | Shared widths and read-buffer state encodings for the ARIA core.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aria_pkg;

  localparam int ARIA_BLK_W  = 128;
  localparam int ARIA_WORD_W = 32;
  localparam int ARIA_SIZE_W = 16;

  typedef enum logic [3:0] {
    ARIA_RB_IDLE     = 4'b0001,
    ARIA_RB_WAIT_BLK = 4'b0010,
    ARIA_RB_SEND     = 4'b0100,
    ARIA_RB_FLUSH    = 4'b1000
  } aria_rb_state_e;

  // The current word is the last one the byte count allows.
  function automatic logic aria_cntr_lst(input logic [ARIA_SIZE_W-1:0] cntr);
    return (cntr < ARIA_SIZE_W'(5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/aria_rd_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aria_rd_buf_if                                                       |
// | Command, result-block and L3 read-data signals of the read buffer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface aria_rd_buf_if;
  import aria_pkg::*;

  logic                   cmd_en;
  logic [ARIA_SIZE_W-1:0] rd_size;
  logic [ARIA_BLK_W-1:0]  rb_d;
  logic                   rb_d_vld;
  logic                   rb_d_lst;
  logic                   rb_d_rdy;
  logic [ARIA_WORD_W-1:0] l3_rd;
  logic                   l3_rd_vld;
  logic                   l3_rd_lst;
  logic                   l3_rd_rdy;
  logic                   rd_busy;
  logic                   rd_under;

  modport master (
    output cmd_en, rd_size, rb_d, rb_d_vld, rb_d_lst, l3_rd_rdy,
    input  rb_d_rdy, l3_rd, l3_rd_vld, l3_rd_lst, rd_busy, rd_under
  );

  modport slave (
    input  cmd_en, rd_size, rb_d, rb_d_vld, rb_d_lst, l3_rd_rdy,
    output rb_d_rdy, l3_rd, l3_rd_vld, l3_rd_lst, rd_busy, rd_under
  );

endinterface
`default_nettype wire

// File: rtl/aria_byte_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aria_byte_mask                                                       |
// | Keeps the top cnt_lo bytes of a word when is_partial is set.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aria_byte_mask
  import aria_pkg::*;
(
  input  logic [1:0]             cnt_lo,
  input  logic                   is_partial,
  output logic [ARIA_WORD_W-1:0] mask
);

  always_comb begin
    mask = {ARIA_WORD_W{1'b1}};
    if (is_partial) begin
      mask = ~({ARIA_WORD_W{1'b1}} >> {cnt_lo, 3'd0});
    end
  end

endmodule
`default_nettype wire

// File: rtl/aria_rd_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aria_rd_buf                                                          |
// | Unpacks 128-bit result blocks MSB-first into 32-bit L3 read words,   |
// | bounded by rd_size. Trailing-byte zeroing: ARIA_RD_BYTE_MASK_EN.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aria_rd_buf
  import aria_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_core,
  aria_rd_buf_if.slave  bus
);

  aria_rb_state_e                     r_state, w_state_nxt;
  logic [ARIA_SIZE_W-1:0]             r_cntr, w_cntr_nxt;
  logic [1:0]                         r_ptr, w_ptr_nxt;
  logic [3:0][ARIA_WORD_W-1:0]        r_buf, w_buf_nxt;
  logic                               r_blk_lst, w_blk_lst_nxt;
  logic                               r_under, w_under_nxt;

  logic                               w_cntr_lst;
  logic                               w_ptr_end;
  logic                               w_is_partial;
  logic [ARIA_WORD_W-1:0]             w_mask;
  logic [ARIA_WORD_W-1:0]             w_word;

  assign w_cntr_lst = aria_cntr_lst(r_cntr);
  assign w_ptr_end  = (r_ptr == 2'd3);
  // Word0 sits in the top lane of the packed buffer, so lane = 3 - ptr.
  assign w_word     = r_buf[~r_ptr];

`ifdef ARIA_RD_BYTE_MASK_EN
  assign w_is_partial = (r_cntr < ARIA_SIZE_W'(4));
`else
  assign w_is_partial = 1'b0;
`endif

  aria_byte_mask u_byte_mask (
    .cnt_lo     (r_cntr[1:0]),
    .is_partial (w_is_partial),
    .mask       (w_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARIA_RB_IDLE;
      r_cntr    <= '0;
      r_ptr     <= '0;
      r_buf     <= '0;
      r_blk_lst <= 1'b0;
      r_under   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cntr    <= w_cntr_nxt;
      r_ptr     <= w_ptr_nxt;
      r_buf     <= w_buf_nxt;
      r_blk_lst <= w_blk_lst_nxt;
      r_under   <= w_under_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cntr_nxt    = r_cntr;
    w_ptr_nxt     = r_ptr;
    w_buf_nxt     = r_buf;
    w_blk_lst_nxt = r_blk_lst;
    w_under_nxt   = r_under;

    if (clr_core) begin
      w_state_nxt   = ARIA_RB_IDLE;
      w_cntr_nxt    = '0;
      w_ptr_nxt     = '0;
      w_buf_nxt     = '0;
      w_blk_lst_nxt = 1'b0;
      w_under_nxt   = 1'b0;
    end else if (bus.cmd_en) begin
      // A new command restarts from any state; buffered words are dropped.
      w_cntr_nxt  = bus.rd_size;
      w_under_nxt = 1'b0;
      w_state_nxt = (bus.rd_size == '0) ? ARIA_RB_IDLE : ARIA_RB_WAIT_BLK;
    end else begin
      case (r_state)
        ARIA_RB_IDLE: begin
          w_state_nxt = ARIA_RB_IDLE;
        end
        ARIA_RB_WAIT_BLK: begin
          if (bus.rb_d_vld) begin
            w_buf_nxt     = bus.rb_d;
            w_blk_lst_nxt = bus.rb_d_lst;
            w_ptr_nxt     = 2'd0;
            w_state_nxt   = ARIA_RB_SEND;
          end
        end
        ARIA_RB_SEND: begin
          if (bus.l3_rd_rdy) begin
            w_cntr_nxt = w_cntr_lst ? '0 : (r_cntr - ARIA_SIZE_W'(4));
            w_ptr_nxt  = r_ptr + 2'd1;
            if (w_cntr_lst) begin
              w_state_nxt = r_blk_lst ? ARIA_RB_IDLE : ARIA_RB_FLUSH;
            end else if (w_ptr_end && r_blk_lst) begin
              w_under_nxt = 1'b1;
              w_state_nxt = ARIA_RB_IDLE;
            end else if (w_ptr_end) begin
              w_state_nxt = ARIA_RB_WAIT_BLK;
            end
          end
        end
        ARIA_RB_FLUSH: begin
          if (bus.rb_d_vld && bus.rb_d_lst) begin
            w_state_nxt = ARIA_RB_IDLE;
          end
        end
        default: begin
          w_state_nxt = ARIA_RB_IDLE;
        end
      endcase
    end
  end

  assign bus.rb_d_rdy  = (r_state == ARIA_RB_WAIT_BLK) || (r_state == ARIA_RB_FLUSH);
  assign bus.l3_rd_vld = (r_state == ARIA_RB_SEND);
  assign bus.l3_rd     = (r_state == ARIA_RB_SEND) ? (w_word & w_mask) : '0;
  assign bus.l3_rd_lst = (r_state == ARIA_RB_SEND) && (w_cntr_lst || (w_ptr_end && r_blk_lst));
  assign bus.rd_busy   = (r_state != ARIA_RB_IDLE);
  assign bus.rd_under  = r_under;

endmodule
`default_nettype wire

// File: tb/tb_aria_rd_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aria_rd_buf                                                       |
// | Directed table, corner sequences and random traffic vs a word model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_aria_rd_buf;
  import aria_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_core = 1'b0;

  always #5 clk = ~clk;

  aria_rd_buf_if bus();

  aria_rd_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_core (clr_core),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] blk_q[$];
  bit           lst_q[$];
  logic [32:0]  exp_q[$];
  bit           exp_under;
  logic [15:0]  cur_size;

`ifdef ARIA_RD_BYTE_MASK_EN
  localparam logic [31:0] C2_W1 = 32'hB1B20000;
`else
  localparam logic [31:0] C2_W1 = 32'hB1B2B3B4;
`endif

  typedef struct packed {
    logic [15:0]        size;
    logic [3:0]         nblk;
    logic [2:0]         lstv;
    logic [2:0][127:0]  blk;
    logic [3:0]         nw;
    logic [4:0][32:0]   w;
    logic               under;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got bound expiry expected completion", name);
  endtask

  // Word stream derived from the byte budget: each word uses up to 4 bytes,
  // the stream stops when bytes run out or the core's last block is exhausted.
  function automatic void model();
    int rem;
    bit done;
    rem = int'(cur_size);
    done = 1'b0;
    exp_q.delete();
    exp_under = 1'b0;
    for (int b = 0; b < blk_q.size() && !done; b++) begin
      for (int w = 0; w < 4 && !done; w++) begin
        logic [31:0] d;
        bit l_cnt, l_blk;
        d = blk_q[b][127-32*w -: 32];
`ifdef ARIA_RD_BYTE_MASK_EN
        for (int k = 0; k < 4; k++) if (k >= rem) d[31-8*k -: 8] = 8'h00;
`endif
        l_cnt = (rem <= 4);
        l_blk = (w == 3) && lst_q[b];
        exp_q.push_back({l_cnt || l_blk, d});
        if (l_cnt) done = 1'b1;
        else if (l_blk) begin
          exp_under = 1'b1;
          done = 1'b1;
        end
        rem = (rem > 4) ? rem - 4 : 0;
      end
    end
  endfunction

  // mode 0: rdy/vld always high, 1: random, 2: rdy pattern 1-0-0-1
  task automatic run_txn(input int mode);
    int bi, widx, cyc;
    bit prev_stall, finished;
    logic [31:0] prev_d;
    logic [3:0] pat;
    pat = 4'b1001;
    bi = 0; widx = 0; cyc = 0;
    prev_stall = 1'b0; prev_d = '0; finished = 1'b0;
    @(negedge clk);
    bus.cmd_en = 1'b1; bus.rd_size = cur_size;
    bus.rb_d_vld = 1'b0; bus.l3_rd_rdy = 1'b0;
    while (!finished) begin
      @(negedge clk);
      bus.cmd_en = 1'b0;
      if (!bus.rd_busy) finished = 1'b1;
      else if (cyc > 1000) begin
        fail_now("txn_timeout");
        finished = 1'b1;
      end else begin
        if (prev_stall) chk("stall_hold", 128'({bus.l3_rd_vld, bus.l3_rd}), 128'({1'b1, prev_d}));
        bus.rb_d_vld  = (bi < blk_q.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
        bus.rb_d      = (bi < blk_q.size()) ? blk_q[bi] : '0;
        bus.rb_d_lst  = (bi < blk_q.size()) ? lst_q[bi] : 1'b0;
        bus.l3_rd_rdy = (mode == 0) ? 1'b1 : (mode == 2) ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
        #1;
        if (bus.l3_rd_vld && bus.l3_rd_rdy) begin
          if (widx < exp_q.size()) chk("word", 128'({bus.l3_rd_lst, bus.l3_rd}), 128'(exp_q[widx]));
          else fail_now("extra_word");
          widx++;
        end
        if (bus.rb_d_vld && bus.rb_d_rdy) bi++;
        prev_stall = bus.l3_rd_vld && !bus.l3_rd_rdy;
        prev_d = bus.l3_rd;
        cyc++;
      end
    end
    bus.rb_d_vld = 1'b0;
    bus.l3_rd_rdy = 1'b0;
    chk("word_count", 128'(widx), 128'(exp_q.size()));
    chk("blk_count", 128'(bi), 128'(blk_q.size()));
    chk("rd_under", 128'(bus.rd_under), 128'(exp_under));
    chk("idle_out", 128'({bus.rb_d_rdy, bus.l3_rd_vld, bus.l3_rd_lst, bus.l3_rd}), 128'd0);
  endtask

  task automatic load_vec(input int i);
    blk_q.delete(); lst_q.delete(); exp_q.delete();
    for (int b = 0; b < int'(vecs[i].nblk); b++) begin
      blk_q.push_back(vecs[i].blk[b]);
      lst_q.push_back(vecs[i].lstv[b]);
    end
    for (int j = 0; j < int'(vecs[i].nw); j++) exp_q.push_back(vecs[i].w[j]);
    exp_under = vecs[i].under;
    cur_size = vecs[i].size;
  endtask

  initial begin
    vecs[0] = '0;
    vecs[0].size = 16'd16; vecs[0].nblk = 4'd1; vecs[0].lstv = 3'b001;
    vecs[0].blk[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vecs[0].nw = 4'd4;
    vecs[0].w[0] = {1'b0, 32'h00112233}; vecs[0].w[1] = {1'b0, 32'h44556677};
    vecs[0].w[2] = {1'b0, 32'h8899AABB}; vecs[0].w[3] = {1'b1, 32'hCCDDEEFF};

    vecs[1] = '0;
    vecs[1].size = 16'd6; vecs[1].nblk = 4'd1; vecs[1].lstv = 3'b001;
    vecs[1].blk[0] = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
    vecs[1].nw = 4'd2;
    vecs[1].w[0] = {1'b0, 32'hA1A2A3A4}; vecs[1].w[1] = {1'b1, C2_W1};

    vecs[2] = '0;
    vecs[2].size = 16'd20; vecs[2].nblk = 4'd3; vecs[2].lstv = 3'b100;
    vecs[2].blk[0] = 128'h10000001_10000002_10000003_10000004;
    vecs[2].blk[1] = 128'h20000001_20000002_20000003_20000004;
    vecs[2].blk[2] = 128'h30000001_30000002_30000003_30000004;
    vecs[2].nw = 4'd5;
    vecs[2].w[0] = {1'b0, 32'h10000001}; vecs[2].w[1] = {1'b0, 32'h10000002};
    vecs[2].w[2] = {1'b0, 32'h10000003}; vecs[2].w[3] = {1'b0, 32'h10000004};
    vecs[2].w[4] = {1'b1, 32'h20000001};

    vecs[3] = '0;
    vecs[3].size = 16'd32; vecs[3].nblk = 4'd1; vecs[3].lstv = 3'b001;
    vecs[3].blk[0] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    vecs[3].nw = 4'd4;
    vecs[3].w[0] = {1'b0, 32'h0F0E0D0C}; vecs[3].w[1] = {1'b0, 32'h0B0A0908};
    vecs[3].w[2] = {1'b0, 32'h07060504}; vecs[3].w[3] = {1'b1, 32'h03020100};
    vecs[3].under = 1'b1;

    bus.cmd_en = 1'b0; bus.rd_size = '0; bus.rb_d = '0;
    bus.rb_d_vld = 1'b0; bus.rb_d_lst = 1'b0; bus.l3_rd_rdy = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_out", 128'({bus.rb_d_rdy, bus.l3_rd_vld, bus.l3_rd_lst, bus.rd_busy, bus.rd_under, bus.l3_rd}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_out", 128'({bus.rb_d_rdy, bus.l3_rd_vld, bus.l3_rd_lst, bus.rd_busy, bus.rd_under, bus.l3_rd}), 128'd0);

    for (int i = 0; i < 4; i++) begin
      load_vec(i);
      run_txn(0);
    end

    // Sticky underrun from the previous command is cleared by clr_core alone.
    @(negedge clk); clr_core = 1'b1;
    @(negedge clk); clr_core = 1'b0;
    chk("clr_under", 128'(bus.rd_under), 128'd0);

    // Zero byte count keeps the buffer idle.
    bus.cmd_en = 1'b1; bus.rd_size = 16'd0;
    @(negedge clk); bus.cmd_en = 1'b0;
    chk("size0_idle", 128'({bus.rd_busy, bus.rb_d_rdy}), 128'd0);

    // clr_core together with cmd_en in the middle of SEND.
    bus.cmd_en = 1'b1; bus.rd_size = 16'd16;
    @(negedge clk); bus.cmd_en = 1'b0;
    chk("wait_rdy", 128'(bus.rb_d_rdy), 128'd1);
    bus.rb_d = vecs[0].blk[0]; bus.rb_d_vld = 1'b1; bus.rb_d_lst = 1'b1; bus.l3_rd_rdy = 1'b0;
    @(negedge clk); bus.rb_d_vld = 1'b0;
    chk("first_word_lat", 128'({bus.l3_rd_vld, bus.l3_rd}), 128'({1'b1, 32'h00112233}));
    clr_core = 1'b1; bus.cmd_en = 1'b1; bus.rd_size = 16'd16;
    @(negedge clk); clr_core = 1'b0; bus.cmd_en = 1'b0;
    chk("clr_mid_send", 128'({bus.rb_d_rdy, bus.l3_rd_vld, bus.l3_rd_lst, bus.rd_busy, bus.rd_under, bus.l3_rd}), 128'd0);

    // cmd_en alone mid-SEND aborts back to waiting for a block.
    bus.cmd_en = 1'b1; bus.rd_size = 16'd16;
    @(negedge clk); bus.cmd_en = 1'b0;
    bus.rb_d = vecs[0].blk[0]; bus.rb_d_vld = 1'b1; bus.rb_d_lst = 1'b1;
    @(negedge clk); bus.rb_d_vld = 1'b0; bus.l3_rd_rdy = 1'b1;
    @(negedge clk); bus.l3_rd_rdy = 1'b0;
    chk("second_word", 128'(bus.l3_rd), 128'(32'h44556677));
    bus.cmd_en = 1'b1; bus.rd_size = 16'd4;
    @(negedge clk); bus.cmd_en = 1'b0;
    chk("abort_state", 128'({bus.rb_d_rdy, bus.l3_rd_vld, bus.rd_busy}), 128'(3'b101));
    blk_q.delete(); lst_q.delete();
    blk_q.push_back(vecs[1].blk[0]); lst_q.push_back(1'b1);
    cur_size = 16'd4;
    model();
    run_txn(1);

    // Stalls with l3_rd_rdy pattern 1-0-0-1.
    load_vec(0);
    run_txn(2);
    load_vec(2);
    run_txn(2);

    for (int t = 0; t < 40; t++) begin
      int nb;
      nb = $urandom_range(1, 4);
      blk_q.delete(); lst_q.delete();
      for (int b = 0; b < nb; b++) begin
        blk_q.push_back({$urandom, $urandom, $urandom, $urandom});
        lst_q.push_back(b == nb - 1);
      end
      cur_size = 16'($urandom_range(1, nb * 16 + 8));
      model();
      run_txn(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
